// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer for the 4-to-1 mux stage.
// It steps the mux select through the channels in ascending order.
// On each channel it holds the select for SETTLE_CYC cycles, then spends one
// SAMPLE cycle capturing the mux output.
// The captured bits form a 4-bit word, and a one-cycle valid_o pulse marks
// each completed scan.
// The scan runs once, or repeats back-to-back while `continuous` is high.
//
// Optional feature: define MUX_SCAN_MASK_EN to add the channel_mask[3:0] input.
// Masked channels are skipped and read back as 0. A mask of all zeros produces
// an immediate valid pulse with data_o = 0.
// Without the macro, all four channels are scanned in the order 0,1,2,3.
module mux_scan_ctrl #(
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       continuous,
  input  logic       abort,
  input  logic       sample_i,
`ifdef MUX_SCAN_MASK_EN
  input  logic [3:0] channel_mask,
`endif
  output logic       enable_,
  output logic [1:0] signal_o,
  output logic [3:0] data_o,
  output logic       valid_o,
  output logic       busy_o
);

  // Settle counter only needs to reach SETTLE_CYC-1.
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       shadow;
  // Set when a continuous scan finds an empty mask, so that IDLE re-accepts
  // on the next cycle without waiting for a start pulse.
  logic             restart_pending;

  logic [3:0]       scan_mask;   // mask governing the scan in progress
  logic [3:0]       accept_mask; // mask that would be captured right now

`ifdef MUX_SCAN_MASK_EN
  logic [3:0]       mask_reg;
  assign scan_mask   = mask_reg;
  assign accept_mask = channel_mask;
`else
  assign scan_mask   = 4'hF;
  assign accept_mask = 4'hF;
`endif

  // Lowest set bit index of m (0 if m is empty; callers guard that case).
  function automatic logic [1:0] lowest_chan(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Bits of m strictly above channel c.
  function automatic logic [3:0] chans_above(input logic [1:0] c,
                                             input logic [3:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 4; i++) begin
      r[i] = m[i] && (i > int'(c));
    end
    return r;
  endfunction

  logic [3:0] higher;
  logic       is_last;
  logic [1:0] next_sel;
  logic [1:0] first_sel;
  logic [3:0] sample_word;

  // Channel-walk helpers and the shadow word including the current sample.
  always_comb begin
    higher      = chans_above(signal_o, scan_mask);
    is_last     = (higher == 4'd0);
    next_sel    = lowest_chan(higher);
    first_sel   = lowest_chan(accept_mask);
    sample_word = shadow;
    sample_word[signal_o] = sample_i;
  end

  // Scan FSM with registered mux controls, result word and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      shadow          <= 4'd0;
      restart_pending <= 1'b0;
      enable_         <= 1'b1;
      signal_o        <= 2'd0;
      data_o          <= 4'd0;
      valid_o         <= 1'b0;
      busy_o          <= 1'b0;
`ifdef MUX_SCAN_MASK_EN
      mask_reg        <= 4'd0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (abort) begin
            // abort beats start and also cancels any pending restart
            restart_pending <= 1'b0;
          end else if (start || restart_pending) begin
            restart_pending <= 1'b0;
            shadow          <= 4'd0;
`ifdef MUX_SCAN_MASK_EN
            mask_reg        <= accept_mask;
`endif
            if (accept_mask == 4'd0) begin
              // nothing to scan: report an empty word straight away
              valid_o         <= 1'b1;
              data_o          <= 4'd0;
              restart_pending <= continuous;
            end else begin
              state    <= SETTLE;
              signal_o <= first_sel;
              enable_  <= 1'b0;
              cnt      <= '0;
              busy_o   <= 1'b1;
            end
          end
        end

        SETTLE: begin
          if (abort) begin
            state    <= IDLE;
            enable_  <= 1'b1;
            signal_o <= 2'd0;
            busy_o   <= 1'b0;
            shadow   <= 4'd0;
            cnt      <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SAMPLE: begin
          if (abort) begin
            // abort outranks completion: no valid pulse, data_o untouched
            state    <= IDLE;
            enable_  <= 1'b1;
            signal_o <= 2'd0;
            busy_o   <= 1'b0;
            shadow   <= 4'd0;
            cnt      <= '0;
          end else if (!is_last) begin
            shadow   <= sample_word;
            signal_o <= next_sel;
            cnt      <= '0;
            state    <= SETTLE;
          end else begin
            data_o  <= sample_word;
            valid_o <= 1'b1;
            shadow  <= 4'd0;
            cnt     <= '0;
            if (continuous && (accept_mask != 4'd0)) begin
              // seamless restart: enable_ stays low, select wraps to first
              state    <= SETTLE;
              signal_o <= first_sel;
`ifdef MUX_SCAN_MASK_EN
              mask_reg <= accept_mask;
`endif
            end else begin
              state           <= IDLE;
              enable_         <= 1'b1;
              signal_o        <= 2'd0;
              busy_o          <= 1'b0;
              // empty mask on a continuous restart is handled from IDLE
              restart_pending <= continuous;
            end
          end
        end

        default: begin
          state    <= IDLE;
          enable_  <= 1'b1;
          signal_o <= 2'd0;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl.
// Instance a (SETTLE_CYC=1) covers reset, the one-shot scan, reset mid-scan,
// abort, and start while busy.
// Instance b (SETTLE_CYC=2) covers continuous scanning.
// The masked-channel cases are compiled in only when MUX_SCAN_MASK_EN is defined.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, cont_a, abort_a;
  logic [3:0] pat_a;
  logic       sample_a;
  logic       en_a, valid_a, busy_a;
  logic [1:0] sig_a;
  logic [3:0] data_a;

  logic       start_b, cont_b, abort_b;
  logic [3:0] pat_b;
  logic       sample_b;
  logic       en_b, valid_b, busy_b;
  logic [1:0] sig_b;
  logic [3:0] data_b;

`ifdef MUX_SCAN_MASK_EN
  logic [3:0] mask_a;
  logic [3:0] mask_b;
`endif

  // The mux model: output is the pattern bit of the selected channel.
  assign sample_a = pat_a[sig_a];
  assign sample_b = pat_b[sig_b];

  mux_scan_ctrl #(.SETTLE_CYC(1)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .continuous (cont_a),
    .abort      (abort_a),
    .sample_i   (sample_a),
`ifdef MUX_SCAN_MASK_EN
    .channel_mask (mask_a),
`endif
    .enable_    (en_a),
    .signal_o   (sig_a),
    .data_o     (data_a),
    .valid_o    (valid_a),
    .busy_o     (busy_a)
  );

  mux_scan_ctrl #(.SETTLE_CYC(2)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .continuous (cont_b),
    .abort      (abort_b),
    .sample_i   (sample_b),
`ifdef MUX_SCAN_MASK_EN
    .channel_mask (mask_b),
`endif
    .enable_    (en_b),
    .signal_o   (sig_b),
    .data_o     (data_b),
    .valid_o    (valid_b),
    .busy_o     (busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are checked on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // One-shot scan on instance a.
  // If glitch is set, start is raised mid-scan and must be ignored.
  task automatic scan_a(input logic glitch, input logic [3:0] exp_word);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_eq("a_sel", 32'(sig_a), 32'(k / 2));
      check_eq("a_en_low", 32'(en_a), 32'd0);
      check_eq("a_valid_low", 32'(valid_a), 32'd0);
      start_a = (glitch && k == 3);
      tick();
    end
    start_a = 1'b0;
    check_eq("a_valid", 32'(valid_a), 32'd1);
    check_eq("a_data", 32'(data_a), 32'(exp_word));
    check_eq("a_busy_done", 32'(busy_a), 32'd0);
    check_eq("a_en_done", 32'(en_a), 32'd1);
    tick();
    check_eq("a_valid_1cyc", 32'(valid_a), 32'd0);
    check_eq("a_data_hold", 32'(data_a), 32'(exp_word));
    check_eq("a_busy_idle", 32'(busy_a), 32'd0);
  endtask

  initial begin
    logic saw_valid;
    reset = 1'b1;
    start_a = 1'b0; cont_a = 1'b0; abort_a = 1'b0; pat_a = 4'b1010;
    start_b = 1'b0; cont_b = 1'b0; abort_b = 1'b0; pat_b = 4'b0110;
`ifdef MUX_SCAN_MASK_EN
    mask_a = 4'hF;
    mask_b = 4'hF;
`endif
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check_eq("rst_en", 32'(en_a), 32'd1);
    check_eq("rst_sel", 32'(sig_a), 32'd0);
    check_eq("rst_data", 32'(data_a), 32'd0);
    check_eq("rst_valid", 32'(valid_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_b_en", 32'(en_b), 32'd1);

    // One-shot scan, pattern 1010.
    scan_a(1'b0, 4'b1010);

    // Reset mid-scan must return to the reset state, clearing data_o.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    check_eq("mid_busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_en", 32'(en_a), 32'd1);
    check_eq("mid_rst_sel", 32'(sig_a), 32'd0);
    check_eq("mid_rst_data", 32'(data_a), 32'd0);
    check_eq("mid_rst_busy", 32'(busy_a), 32'd0);
    check_eq("mid_rst_valid", 32'(valid_a), 32'd0);
    tick();

    // A start pulse while busy must not change the scan length.
    scan_a(1'b1, 4'b1010);

    // Abort while channel 2 is selected.
    pat_a = 4'b0101;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_eq("ab_sel2", 32'(sig_a), 32'd2);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check_eq("ab_busy", 32'(busy_a), 32'd0);
    check_eq("ab_en", 32'(en_a), 32'd1);
    check_eq("ab_sel", 32'(sig_a), 32'd0);
    check_eq("ab_valid", 32'(valid_a), 32'd0);
    check_eq("ab_data", 32'(data_a), 32'b1010);
    saw_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (valid_a) saw_valid = 1'b1;
    end
    check_eq("ab_no_valid", 32'(saw_valid), 32'd0);
    check_eq("ab_still_idle", 32'(busy_a), 32'd0);

    // start and abort together in IDLE: abort wins.
    start_a = 1'b1;
    abort_a = 1'b1;
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    check_eq("sa_busy", 32'(busy_a), 32'd0);
    check_eq("sa_en", 32'(en_a), 32'd1);

    // Continuous scanning on instance b (SETTLE_CYC=2, 12 cycles per scan).
    cont_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int n = 1; n <= 48; n++) begin
      tick();
      check_eq($sformatf("b_valid_%0d", n), 32'(valid_b), 32'((n % 12) == 0));
      check_eq($sformatf("b_en_%0d", n), 32'(en_b), 32'(n == 48));
      check_eq($sformatf("b_sel_%0d", n), 32'(sig_b), 32'((n % 12) / 3));
      if ((n % 12) == 0)
        check_eq($sformatf("b_data_%0d", n), 32'(data_b), 32'b0110);
      if (n == 40) cont_b = 1'b0;
    end
    tick();
    check_eq("b_busy_end", 32'(busy_b), 32'd0);
    check_eq("b_valid_end", 32'(valid_b), 32'd0);

`ifdef MUX_SCAN_MASK_EN
    // Mask 1001: only channels 0 and 3 are scanned.
    pat_a = 4'b1111;
    mask_a = 4'b1001;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("m_sel", 32'(sig_a), (k < 2) ? 32'd0 : 32'd3);
      check_eq("m_valid_low", 32'(valid_a), 32'd0);
      tick();
    end
    check_eq("m_valid", 32'(valid_a), 32'd1);
    check_eq("m_data", 32'(data_a), 32'b1001);
    tick();

    // Empty mask: immediate valid with data 0; no scan is started.
    mask_a = 4'b0000;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_eq("m0_valid", 32'(valid_a), 32'd1);
    check_eq("m0_data", 32'(data_a), 32'd0);
    check_eq("m0_en", 32'(en_a), 32'd1);
    check_eq("m0_busy", 32'(busy_a), 32'd0);
    tick();
    check_eq("m0_valid_1cyc", 32'(valid_a), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
